// File: rtl/oka_seq_gf2_mult.sv
// oka_seq_gf2_mult
// Iterative overlap-free Karatsuba multiplier over GF(2)[x], N x N -> 2N-1 bits.
// Operands are split into even/odd coefficient halves. A single H x H carry-less core
// (H = N/2) is reused over three cycles for EE, OO and MID, after which the interleaved
// overlap recombination is registered into res.
//
// Optional feature macro: OKA_MODRED_EN
//   Adds a RED state, the res_red port and a one-cycle modular fold by x^N + POLY.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      high only in IDLE
//   a, b       in   N      operands, bit i = coefficient of x^i
//   out_valid  out  1      result valid (DONE)
//   out_ready  in   1      consumer accepts result
//   res        out  2N-1   unreduced product
//   res_red    out  N      reduced product (OKA_MODRED_EN only)
//   busy       out  1      high whenever not IDLE
module oka_seq_gf2_mult #(
    parameter int unsigned  N    = 16,
    parameter logic [N-1:0] POLY = 16'h100B
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-2:0] res,
`ifdef OKA_MODRED_EN
    output logic [N-1:0]   res_red,
`endif
    output logic           busy
);

    localparam int unsigned H  = N / 2;
    localparam int unsigned W  = 2 * N - 1;
    localparam int          NI = N;

`ifdef OKA_MODRED_EN
    typedef enum logic [2:0] {StIdle, StMulEe, StMulOo, StMulMid, StRed, StDone} state_e;
`else
    typedef enum logic [2:0] {StIdle, StMulEe, StMulOo, StMulMid, StDone} state_e;
`endif

    state_e state_q, state_d;

    logic [N-1:0] a_q, a_d, b_q, b_d;
    logic [N-2:0] pee_q, pee_d, poo_q, poo_d;
    logic [W-1:0] res_q, res_d;
    logic [H-1:0] a_e, a_o, b_e, b_o;
    logic [H-1:0] core_x, core_y;
    logic [N-2:0] core_p, x_mid;
    logic [W-1:0] res_ovl;

    // H x H carry-less product, degree <= N-2
    function automatic logic [N-2:0] clmul_h(input logic [H-1:0] x, input logic [H-1:0] y);
        logic [N-2:0] p;
        p = '0;
        for (int i = 0; i < int'(H); i++) begin
            if (y[i]) p = p ^ ({{(N-1-H){1'b0}}, x} << i);
        end
        return p;
    endfunction

`ifdef OKA_MODRED_EN
    logic [N-1:0] red_q, red_d;

    // Fold from the top coefficient down, replacing x^N by POLY each time
    function automatic logic [N-1:0] fold(input logic [W-1:0] p);
        logic [W-1:0] r;
        r = p;
        for (int i = int'(W) - 1; i >= NI; i--) begin
            if (r[i]) begin
                r[i-NI +: N] = r[i-NI +: N] ^ POLY;
                r[i]         = 1'b0;
            end
        end
        return r[N-1:0];
    endfunction

    assign res_red = red_q;
`endif

    always_comb begin
        a_e = '0;
        a_o = '0;
        b_e = '0;
        b_o = '0;
        for (int i = 0; i < int'(H); i++) begin
            a_e[i] = a_q[2*i];
            a_o[i] = a_q[2*i+1];
            b_e[i] = b_q[2*i];
            b_o[i] = b_q[2*i+1];
        end
    end

    // Shared core operand select
    always_comb begin
        core_x = a_e;
        core_y = b_e;
        case (state_q)
            StMulOo: begin
                core_x = a_o;
                core_y = b_o;
            end
            StMulMid: begin
                core_x = a_e ^ a_o;
                core_y = b_e ^ b_o;
            end
            default: ;
        endcase
    end

    assign core_p = clmul_h(core_x, core_y);
    assign x_mid  = core_p ^ pee_q ^ poo_q;

    // Even result bits take Pee[i] ^ Poo[i-1]; odd bits take the middle term
    always_comb begin
        logic [N-1:0] pee_x, poo_x;
        res_ovl = '0;
        pee_x   = {1'b0, pee_q};
        poo_x   = {poo_q, 1'b0};
        for (int i = 0; i < NI; i++) begin
            res_ovl[2*i] = pee_x[i] ^ poo_x[i];
        end
        for (int i = 0; i < NI - 1; i++) begin
            res_ovl[2*i+1] = x_mid[i];
        end
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        pee_d = pee_q;
        poo_d = poo_q;
        res_d = res_q;
`ifdef OKA_MODRED_EN
        red_d = red_q;
`endif
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d = a;
                    b_d = b;
                end
            end
            StMulEe:  pee_d = core_p;
            StMulOo:  poo_d = core_p;
            StMulMid: res_d = res_ovl;
`ifdef OKA_MODRED_EN
            StRed:    red_d = fold(res_q);
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            pee_q <= '0;
            poo_q <= '0;
            res_q <= '0;
`ifdef OKA_MODRED_EN
            red_q <= '0;
`endif
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            pee_q <= pee_d;
            poo_q <= poo_d;
            res_q <= res_d;
`ifdef OKA_MODRED_EN
            red_q <= red_d;
`endif
        end
    end

    assign res = res_q;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (in_valid) state_d = StMulEe;
            StMulEe:  state_d = StMulOo;
            StMulOo:  state_d = StMulMid;
`ifdef OKA_MODRED_EN
            StMulMid: state_d = StRed;
            StRed:    state_d = StDone;
`else
            StMulMid: state_d = StDone;
`endif
            StDone:   if (out_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
    end

endmodule

// File: tb/tb_oka_seq_gf2_mult.sv
module tb_oka_seq_gf2_mult;

    localparam int          N    = 16;
    localparam int          W    = 2 * N - 1;
    localparam logic [15:0] POLY = 16'h100B;
`ifdef OKA_MODRED_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a, b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  res;
    logic [N-1:0]  res_red;
    logic          busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    oka_seq_gf2_mult #(.N(N), .POLY(POLY)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
`ifdef OKA_MODRED_EN
        .res_red   (res_red),
`endif
        .busy      (busy)
    );

`ifndef OKA_MODRED_EN
    assign res_red = '0;
`endif

    // Bit-serial schoolbook carry-less product
    function automatic logic [W-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [W-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++) if (y[j]) r = r ^ (W'(x) << j);
        return r;
    endfunction

    // Sum of x^k mod (x^16 + POLY) over the set coefficients, x^k stepped LFSR-style
    function automatic logic [N-1:0] ref_red(input logic [W-1:0] p);
        logic [N:0]   t;
        logic [N-1:0] acc;
        t   = 17'h1;
        acc = '0;
        for (int k = 0; k < W; k++) begin
            if (p[k]) acc = acc ^ t[N-1:0];
            t = t << 1;
            if (t[N]) t = t ^ {1'b1, POLY};
        end
        return acc;
    endfunction

    logic [N-1:0] dir_a   [6] = '{16'h0003, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 16'hA5C3};
    logic [N-1:0] dir_b   [6] = '{16'h0003, 16'h8000, 16'h0001, 16'h1234, 16'h0002, 16'h0001};
    logic [W-1:0] dir_res [6] = '{31'h0000_0005, 31'h4000_0000, 31'h0000_FFFF, 31'h0,
                                  31'h0001_0000, 31'h0000_A5C3};

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || res !== '0
            || res_red !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b res=%h red=%h want 1 0 0 0 0",
                     in_ready, out_valid, busy, res, res_red);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b busy=%b want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_directed();
        for (int k = 0; k < 6; k++) begin
            int lat;
            @(negedge clk);
            a = dir_a[k]; b = dir_b[k]; in_valid = 1'b1; out_ready = 1'b0;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL dir%0d_in_ready: got %b want 1", k, in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0; a = $urandom; b = $urandom;
            lat = 1;
            while (out_valid !== 1'b1 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            n_cmp++;
            if (lat != LAT) begin
                n_fail++;
                $display("FAIL dir%0d_latency: got %0d want %0d", k, lat, LAT);
            end
            n_cmp++;
            if (res !== dir_res[k]) begin
                n_fail++;
                $display("FAIL dir%0d_res: got %h want %h", k, res, dir_res[k]);
            end
`ifdef OKA_MODRED_EN
            n_cmp++;
            if (res_red !== ref_red(dir_res[k])) begin
                n_fail++;
                $display("FAIL dir%0d_res_red: got %h want %h", k, res_red, ref_red(dir_res[k]));
            end
`endif
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL dir%0d_release: got vld=%b rdy=%b want 0 1", k, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_hold();
        logic [N-1:0] ha, hb;
        logic [W-1:0] exp;
        int           lat;
        ha  = $urandom | 16'h0101;
        hb  = $urandom | 16'h0011;
        exp = ref_mul(ha, hb);
        @(negedge clk);
        a = ha; b = hb; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        for (int c = 0; c < 10; c++) begin
            in_valid = $urandom_range(0, 1); a = $urandom; b = $urandom; out_ready = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || res !== exp) begin
                n_fail++;
                $display("FAIL hold_c%0d: got vld=%b rdy=%b busy=%b res=%h want 1 0 1 %h",
                         c, out_valid, in_ready, busy, res, exp);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || res !== exp) begin
            n_fail++;
            $display("FAIL hold_release: got vld=%b rdy=%b res=%h want 0 1 %h",
                     out_valid, in_ready, res, exp);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_idle_c%0d: got vld=%b busy=%b want 0 0", c, out_valid, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_busy: got %b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || res !== '0
            || res_red !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async: got rdy=%b vld=%b busy=%b res=%h red=%h want 1 0 0 0 0",
                     in_ready, out_valid, busy, res, res_red);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_dropped_c%0d: got vld=%b want 0", c, out_valid);
            end
        end
        a = 16'h0003; b = 16'h0003; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat != LAT || res !== 31'h5) begin
            n_fail++;
            $display("FAIL rstmid_next_op: got lat=%0d res=%h want %0d 00000005", lat, res, LAT);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_q[$];
        logic [W-1:0] e;
        int           sent = 0;
        int           got  = 0;
        int           cyc  = 0;
        while ((sent < 1000 || exp_q.size() != 0) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            out_ready = $urandom_range(0, 1);
            if (out_valid === 1'b1 && out_ready) begin
                got++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_dup: got res=%h with no outstanding op", res);
                end else begin
                    e = exp_q.pop_front();
                    if (res !== e) begin
                        n_fail++;
                        $display("FAIL b2b_res%0d: got %h want %h", got, res, e);
                    end
`ifdef OKA_MODRED_EN
                    n_cmp++;
                    if (res_red !== ref_red(e)) begin
                        n_fail++;
                        $display("FAIL b2b_red%0d: got %h want %h", got, res_red, ref_red(e));
                    end
`endif
                end
            end
            a = $urandom; b = $urandom;
            in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            if (in_valid && in_ready === 1'b1) begin
                exp_q.push_back(ref_mul(a, b));
                sent++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if (got != 1000 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results (%0d pending) want 1000 (0)",
                     got, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
